// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline control bundle between the stall sequencer and the pipeline/data-memory side.
// slave = the sequencer, master = the pipeline/hazard/memory side driving requests.
interface pipeline_stall_ctrl_if;
   logic start_i;
   logic load_use_i;
   logic branch_taken_i;
   logic dmem_req_i;
   logic dmem_ready_i;
   logic dmem_start_o;
   logic pc_write_o;
   logic ifid_write_o;
   logic ifid_flush_o;
   logic idex_bubble_o;
   logic pipe_stall_o;

   modport slave (
      input  start_i, load_use_i, branch_taken_i, dmem_req_i, dmem_ready_i,
      output dmem_start_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o
   );

   modport master (
      output start_i, load_use_i, branch_taken_i, dmem_req_i, dmem_ready_i,
      input  dmem_start_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, taken-branch and dmem waits.
// Define STALL_CNT_EN to build the saturating stall/flush performance counters.
//
// state      | meaning
// S_IDLE     | not executing; waits for start_i, everything held off
// S_RUN      | normal flow; load-use bubbles and branch flushes handled here
// S_MEM_WAIT | data-memory access outstanding; pipeline frozen until dmem_ready_i
module pipeline_stall_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   pipeline_stall_ctrl_if.slave    bus,
   output logic [CNT_W-1:0]        stall_cycles_o,
   output logic [CNT_W-1:0]        flush_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_WAIT} state_t;

   state_t state_q, state_d;
   logic   dmem_start, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_stall;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      dmem_start  = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_stall  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.dmem_req_i) begin
               dmem_start = 1'b1;
               pipe_stall = 1'b1;
               state_d    = S_MEM_WAIT;
            end else if (bus.load_use_i) begin
               idex_bubble = 1'b1;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = bus.branch_taken_i;
            end
         end
         S_MEM_WAIT: begin
            // On the ready cycle dmem_req_i still shows the finished access, so it is not re-launched.
            if (bus.dmem_ready_i) begin
               state_d = S_RUN;
               if (bus.load_use_i) begin
                  idex_bubble = 1'b1;
               end else begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
                  ifid_flush = bus.branch_taken_i;
               end
            end else begin
               pipe_stall = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.dmem_start_o  = dmem_start;
   assign bus.pc_write_o    = pc_write;
   assign bus.ifid_write_o  = ifid_write;
   assign bus.ifid_flush_o  = ifid_flush;
   assign bus.idex_bubble_o = idex_bubble;
   assign bus.pipe_stall_o  = pipe_stall;

`ifdef STALL_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((pipe_stall || idex_bubble) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (ifid_flush && (flush_cnt_q != '1))                  flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
   assign flush_cnt_o    = flush_cnt_q;
`else
   assign stall_cycles_o = '0;
   assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; counter expectations follow STALL_CNT_EN.
module tb_pipeline_stall_ctrl;
   localparam int CNT_W = 4;
`ifdef STALL_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic [CNT_W-1:0] stall_cycles_o, flush_cnt_o;
   logic [5:0] outs;
   int n_checks = 0;
   int n_fail   = 0;

   pipeline_stall_ctrl_if bus();

   pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .bus            (bus),
      .stall_cycles_o (stall_cycles_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // {dmem_start, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_stall}
   assign outs = {bus.dmem_start_o, bus.pc_write_o, bus.ifid_write_o,
                  bus.ifid_flush_o, bus.idex_bubble_o, bus.pipe_stall_o};

   function automatic logic [CNT_W-1:0] cexp(input int v);
      return CNT_ON ? CNT_W'(v) : '0;
   endfunction

   task automatic drive(input logic st, input logic lu, input logic br,
                        input logic rq, input logic rd);
      @(posedge clk_i);
      #1;
      bus.start_i        = st;
      bus.load_use_i     = lu;
      bus.branch_taken_i = br;
      bus.dmem_req_i     = rq;
      bus.dmem_ready_i   = rd;
   endtask

   task automatic test_reset;
      bus.start_i = 0; bus.load_use_i = 0; bus.branch_taken_i = 0;
      bus.dmem_req_i = 0; bus.dmem_ready_i = 0;
      rst_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000000) begin
         n_fail++; $display("FAIL reset_outs got %b want %b", outs, 6'b000000);
      end
      n_checks++;
      if (stall_cycles_o !== '0 || flush_cnt_o !== '0) begin
         n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles_o, flush_cnt_o);
      end
      rst_i = 1'b1;
   endtask

   task automatic test_start;
      drive(1, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000000) begin
         n_fail++; $display("FAIL idle_outs got %b want %b", outs, 6'b000000);
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b011000) begin
         n_fail++; $display("FAIL start_run got %b want %b", outs, 6'b011000);
      end
   endtask

   task automatic test_load_branch;
      drive(0, 1, 1, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000010) begin
         n_fail++; $display("FAIL lu_over_branch got %b want %b", outs, 6'b000010);
      end
      drive(0, 0, 1, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b011100) begin
         n_fail++; $display("FAIL branch_flush got %b want %b", outs, 6'b011100);
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (stall_cycles_o !== cexp(1) || flush_cnt_o !== cexp(1)) begin
         n_fail++; $display("FAIL lb_counters got %0d/%0d want %0d/%0d",
                            stall_cycles_o, flush_cnt_o, cexp(1), cexp(1));
      end
   endtask

   task automatic test_mem_wait;
      drive(0, 0, 0, 1, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b100001) begin
         n_fail++; $display("FAIL mem_launch got %b want %b", outs, 6'b100001);
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, 0);
         @(negedge clk_i);
         n_checks++;
         if (outs !== 6'b000001) begin
            n_fail++; $display("FAIL mem_wait%0d got %b want %b", i, outs, 6'b000001);
         end
      end
      drive(0, 0, 0, 1, 1);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b011000) begin
         n_fail++; $display("FAIL mem_ready got %b want %b", outs, 6'b011000);
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b011000) begin
         n_fail++; $display("FAIL mem_resume got %b want %b", outs, 6'b011000);
      end
      n_checks++;
      if (stall_cycles_o !== cexp(4) || flush_cnt_o !== cexp(1)) begin
         n_fail++; $display("FAIL mem_counters got %0d/%0d want %0d/%0d",
                            stall_cycles_o, flush_cnt_o, cexp(4), cexp(1));
      end
   endtask

   task automatic test_ready_load_use;
      drive(0, 0, 0, 1, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b100001) begin
         n_fail++; $display("FAIL rlu_launch got %b want %b", outs, 6'b100001);
      end
      drive(0, 1, 1, 1, 1);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000010) begin
         n_fail++; $display("FAIL rlu_ready got %b want %b", outs, 6'b000010);
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b011000) begin
         n_fail++; $display("FAIL rlu_run got %b want %b", outs, 6'b011000);
      end
      drive(1, 0, 0, 0, 1);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b011000) begin
         n_fail++; $display("FAIL spurious_ready got %b want %b", outs, 6'b011000);
      end
   endtask

   task automatic test_reset_mid_wait;
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000001 || stall_cycles_o !== cexp(7)) begin
         n_fail++; $display("FAIL pre_reset got %b/%0d want %b/%0d",
                            outs, stall_cycles_o, 6'b000001, cexp(7));
      end
      #1 rst_i = 1'b0;
      #1;
      n_checks++;
      if (outs !== 6'b000000 || stall_cycles_o !== '0 || flush_cnt_o !== '0) begin
         n_fail++; $display("FAIL async_reset got %b/%0d/%0d want 000000/0/0",
                            outs, stall_cycles_o, flush_cnt_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      drive(0, 0, 0, 1, 1);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000000) begin
         n_fail++; $display("FAIL late_ready_idle got %b want %b", outs, 6'b000000);
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000000) begin
         n_fail++; $display("FAIL still_idle got %b want %b", outs, 6'b000000);
      end
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b011000 || stall_cycles_o !== '0) begin
         n_fail++; $display("FAIL restart got %b/%0d want %b/0", outs, stall_cycles_o, 6'b011000);
      end
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (outs !== 6'b000010) begin
         n_fail++; $display("FAIL sat_bubble got %b want %b", outs, 6'b000010);
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk_i);
      n_checks++;
      if (stall_cycles_o !== cexp(15) || flush_cnt_o !== '0) begin
         n_fail++; $display("FAIL saturate got %0d/%0d want %0d/0",
                            stall_cycles_o, flush_cnt_o, cexp(15));
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_load_branch();
      test_mem_wait();
      test_ready_load_use();
      test_reset_mid_wait();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges the load-use stall from hazard detection, taken-branch flush requests from the ID stage and a variable-latency data-memory handshake from the MEM stage, then drives one consistent set of write-enable, flush and bubble controls to the PC and the pipeline registers. It sits beside the hazard detection unit and between the pipeline registers and the data-memory interface.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (counters exist only when the configuration macro is defined)

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin execution; sampled only in IDLE
- load_use_i  in  1  load-use hazard flag from hazard detection
- branch_taken_i  in  1  ID-stage branch/jump resolved taken
- dmem_req_i  in  1  MEM stage holds a load or store
- dmem_ready_i  in  1  one-cycle pulse: memory access complete
- dmem_start_o  out  1  one-cycle pulse: launch memory access
- pc_write_o  out  1  PC write enable
- ifid_write_o  out  1  IF/ID register write enable
- ifid_flush_o  out  1  clear IF/ID to NOP
- idex_bubble_o  out  1  insert NOP control into ID/EX
- pipe_stall_o  out  1  freeze PC and all four pipeline registers
- stall_cycles_o  out  CNT_W  cycles spent stalled (memory or load-use)
- flush_cnt_o  out  CNT_W  taken-branch flushes issued

## Operation
- FSM states: IDLE, RUN, MEM_WAIT; reset state IDLE.
- IDLE: pc_write_o=0, ifid_write_o=0, all other controls 0. start_i=1 -> RUN next cycle. dmem_ready_i ignored.
- RUN, priority high to low:
  - dmem_req_i=1: dmem_start_o=1, pipe_stall_o=1, pc_write_o=0, ifid_write_o=0, no flush/bubble; next state MEM_WAIT.
  - load_use_i=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; branch_taken_i ignored this cycle (it is re-evaluated when the held instruction proceeds).
  - branch_taken_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
  - otherwise: pc_write_o=1, ifid_write_o=1, others 0.
- MEM_WAIT: dmem_start_o=0. Until dmem_ready_i arrives: pipe_stall_o=1, pc_write_o=0, ifid_write_o=0, all else 0. The cycle dmem_ready_i=1: pipe_stall_o=0 and the RUN priority rules apply to load_use_i/branch_taken_i (dmem_req_i is ignored that cycle because it still reflects the completed access); next state RUN.
- dmem_ready_i while in RUN is spurious and ignored.
- start_i in RUN or MEM_WAIT is ignored.
- All outputs except the counters are combinational from state and inputs. The counters are registered.

## Timing
- Reset (rst_i=0, asynchronous): state=IDLE, all 1-bit outputs 0, counters 0. Applies immediately, including mid MEM_WAIT. An outstanding access is abandoned, and its late dmem_ready_i is ignored in IDLE.
- Start latency: start_i sampled high at edge N -> pc_write_o=1 in cycle N+1.
- Memory stall: dmem_start_o is high for exactly one cycle, in the RUN cycle that sees dmem_req_i. The pipeline is frozen from that cycle through the cycle before dmem_ready_i. A ready arriving k cycles after start gives a k-cycle freeze; the minimum is k=1, where ready is asserted in the first MEM_WAIT cycle.
- Load-use: 1 bubble cycle per asserted cycle of load_use_i. No internal state.
- Counters: stall_cycles_o increments by 1 on each clock edge where pipe_stall_o or idex_bubble_o was high. flush_cnt_o increments on each edge where ifid_flush_o was high. Both saturate at all-ones and do not wrap.

## Configuration
- STALL_CNT_EN:
  - Defined: both counters are built as specified.
  - Undefined: no counter flops are built, and stall_cycles_o and flush_cnt_o are tied to 0. Port list unchanged.

## Test plan
- Reset then start_i pulse -> outputs all 0 during reset; pc_write_o=1, ifid_write_o=1 the cycle after start.
- RUN, load_use_i=1 and branch_taken_i=1 for one cycle -> idex_bubble_o=1, pc_write_o=0, ifid_flush_o=0; next cycle with branch_taken_i=1 only -> ifid_flush_o=1; counters read stall=1, flush=1.
- dmem_req_i=1 with ready returned 3 cycles after dmem_start_o -> single-cycle dmem_start_o, pipe_stall_o=1 for 3 cycles, resume on ready cycle, stall_cycles_o=3, no second dmem_start_o.
- Ready cycle coinciding with load_use_i=1 -> pipe_stall_o=0, idex_bubble_o=1, state returns RUN.
- rst_i low during MEM_WAIT, then dmem_ready_i pulse while in IDLE -> state IDLE, counters 0, no outputs asserted; start_i resumes cleanly.
- CNT_W=4, 20 consecutive load-use cycles with STALL_CNT_EN defined -> stall_cycles_o holds 15. Same test without the macro -> stall_cycles_o stays 0.
